// File: rtl/uart_console_if.sv
// Console-to-UART bus: byte strobe in, line and status out.
interface uart_console_if;
  logic [8:0] sys_odata;     // [8] write strobe, [7:0] byte
  logic       serial_tx;
  logic       fifo_full;
  logic       busy;
  logic [7:0] overflow_cnt;

  modport master (
    output sys_odata,
    input  serial_tx,
    input  fifo_full,
    input  busy,
    input  overflow_cnt
  );

  modport slave (
    input  sys_odata,
    output serial_tx,
    output fifo_full,
    output busy,
    output overflow_cnt
  );
endinterface

// File: rtl/uart_console_tx.sv
// 8N1 UART transmitter for console output, with a small FIFO to absorb bursts
// (the console cannot be stalled) and a saturating dropped-byte counter.
module uart_console_tx #(
  parameter int unsigned DIVISOR   = 543,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_console_if.slave con
);

  localparam int unsigned          Depth      = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   DepthCnt   = Depth[FIFO_LOG2:0];
  localparam logic [FIFO_LOG2:0]   PtrOne     = 1;
  localparam logic [15:0]          BaudReload = 16'(DIVISOR - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [15:0]          baud_q;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 tx_q;

  logic [7:0]           mem_q [Depth];
  logic [FIFO_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic                 fifo_full_q;
  logic [7:0]           ovf_q;

  logic [FIFO_LOG2:0]   occ, occ_next;
  logic                 empty, full, push_req, push, pop;
  logic [7:0]           rd_data;

  // Full/empty come from pre-edge pointers, so a pop never makes room for a
  // push on the same edge.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign empty    = (occ == '0);
  assign full     = (occ == DepthCnt);
  assign push_req = con.sys_odata[8];
  assign push     = push_req & ~full;
  assign pop      = ~empty & ((state_q == StIdle) | ((state_q == StStop) & (baud_q == '0)));
  assign rd_data  = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

  // Post-edge occupancy, used to register fifo_full.
  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + PtrOne;
    end else if (pop && !push) begin
      occ_next = occ - PtrOne;
    end
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= con.sys_odata[7:0];
    end
  end

  // FIFO pointers, registered full flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_full_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      fifo_full_q <= (occ_next == DepthCnt);
      if (push_req && full && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  // Framing FSM; serial_tx is set together with each state change so the
  // line comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= rd_data;
            baud_q  <= BaudReload;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            baud_q    <= BaudReload;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StData: begin
          if (baud_q == '0) begin
            baud_q <= BaudReload;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        StStop: begin
          if (baud_q == '0) begin
            if (pop) begin
              // Back-to-back frame: no idle gap after the stop bit.
              shift_q <= rd_data;
              baud_q  <= BaudReload;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign con.serial_tx    = tx_q;
  assign con.fifo_full    = fifo_full_q;
  assign con.busy         = (state_q != StIdle) | ~empty;
  assign con.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_uart_console_tx.sv
// Directed bench for uart_console_tx: frame timing, back-to-back frames,
// FIFO overflow, counter saturation, mid-frame reset and a receiver model.
module tb_uart_console_tx;

  localparam int unsigned Div2 = 2;

  logic clk = 1'b0;
  logic rst4 = 1'b1, rst_big = 1'b1, rst2 = 1'b1;
  int   n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  uart_console_if if4 ();
  uart_console_if if_big ();
  uart_console_if if2 ();

  uart_console_tx #(.DIVISOR(4), .FIFO_LOG2(4)) u_dut4 (
    .clk (clk), .rst (rst4), .con (if4)
  );
  uart_console_tx #(.DIVISOR(65535), .FIFO_LOG2(4)) u_dut_big (
    .clk (clk), .rst (rst_big), .con (if_big)
  );
  uart_console_tx #(.DIVISOR(Div2), .FIFO_LOG2(4)) u_dut2 (
    .clk (clk), .rst (rst2), .con (if2)
  );

  // Per-edge stimulus and observations for the DIVISOR=4 instance.
  logic       st_v  [0:1023];
  logic [7:0] st_b  [0:1023];
  logic       tx_o  [0:1023];
  logic       full_o[0:1023];
  logic       busy_o[0:1023];
  logic [7:0] ovf_o [0:1023];

  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 1024; i++) begin
      st_v[i] = 1'b0;
      st_b[i] = 8'h00;
    end
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    tick();
    tick();
    rst4 = 1'b0;
  endtask

  // Edge e is the e-th posedge after the call; results sampled on the negedge after it.
  task automatic run4(input int n);
    for (int e = 0; e < n; e++) begin
      if4.sys_odata = st_v[e] ? {1'b1, st_b[e]} : {1'b0, 8'h5A};
      tick();
      tx_o[e]   = if4.serial_tx;
      full_o[e] = if4.fifo_full;
      busy_o[e] = if4.busy;
      ovf_o[e]  = if4.overflow_cnt;
    end
    if4.sys_odata = '0;
  endtask

  // Expected line level over one frame, index 0 = first start-bit cycle.
  function automatic logic [39:0] frame_pat(input logic [7:0] b);
    logic [39:0] f;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       f[k] = 1'b0;
      else if (k < 36) f[k] = b[(k - 4) / 4];
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [39:0] get_frame(input int s);
    logic [39:0] f;
    for (int k = 0; k < 40; k++) f[k] = tx_o[s + k];
    return f;
  endfunction

  // UART receiver on the DIVISOR=2 line, sampling the first cycle of each bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst2 && if2.serial_tx == 1'b0) begin
        repeat (Div2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = if2.serial_tx;
          repeat (Div2) @(negedge clk);
        end
        if (if2.serial_tx !== 1'b1) rx_frame_err++;
        rx_q.push_back(b);
        repeat (Div2 - 1) @(negedge clk);
      end
    end
  end

  initial begin
    int bad, prev, wraps, j, waited;
    logic v;
    if4.sys_odata = '0;
    if_big.sys_odata = '0;
    if2.sys_odata = '0;
    clear_stim();
    tick();
    tick();

    // Reset state
    check("rst_tx", if4.serial_tx, 1);
    check("rst_busy", if4.busy, 0);
    check("rst_full", if4.fifo_full, 0);
    check("rst_ovf", if4.overflow_cnt, 0);
    rst4 = 1'b0;
    tick();
    check("idle_tx", if4.serial_tx, 1);

    // 1: single 0x55
    clear_stim();
    st_v[0] = 1'b1; st_b[0] = 8'h55;
    run4(45);
    check("t1_tx_e0", tx_o[0], 1);
    check("t1_busy_e0", busy_o[0], 1);
    check("t1_frame", get_frame(1), frame_pat(8'h55));
    check("t1_busy_e40", busy_o[40], 1);
    check("t1_busy_e41", busy_o[41], 0);
    check("t1_tx_e41", tx_o[41], 1);

    // 2: 0x41, 0x42 back to back
    reset4();
    clear_stim();
    st_v[0] = 1'b1; st_b[0] = 8'h41;
    st_v[1] = 1'b1; st_b[1] = 8'h42;
    run4(85);
    check("t2_frame0", get_frame(1), frame_pat(8'h41));
    check("t2_frame1", get_frame(41), frame_pat(8'h42));
    check("t2_busy_e80", busy_o[80], 1);
    check("t2_busy_e81", busy_o[81], 0);

    // 3: 20 strobes, 17 accepted, 3 dropped
    reset4();
    clear_stim();
    for (int e = 0; e < 20; e++) begin
      st_v[e] = 1'b1;
      st_b[e] = 8'(8'h10 + e * 13);
    end
    run4(685);
    check("t3_full_e15", full_o[15], 0);
    check("t3_full_e16", full_o[16], 1);
    check("t3_ovf_e16", ovf_o[16], 0);
    check("t3_ovf_e17", ovf_o[17], 1);
    check("t3_ovf_e19", ovf_o[19], 3);
    check("t3_full_e40", full_o[40], 1);
    check("t3_full_e41", full_o[41], 0);
    for (int f = 0; f < 17; f++) begin
      check($sformatf("t3_frame%0d", f), get_frame(1 + 40 * f), frame_pat(st_b[f]));
    end
    check("t3_ovf_end", ovf_o[684], 3);
    check("t3_busy_end", busy_o[684], 0);

    // 5: reset mid-DATA with 5 bytes queued
    reset4();
    clear_stim();
    for (int e = 0; e < 6; e++) begin
      st_v[e] = 1'b1;
      st_b[e] = 8'hA5;
    end
    run4(11);
    check("t5_tx_before", tx_o[10], 0);
    check("t5_busy_before", busy_o[10], 1);
    #1 rst4 = 1'b1;
    #1;
    check("t5_tx_rst", if4.serial_tx, 1);
    check("t5_busy_rst", if4.busy, 0);
    check("t5_full_rst", if4.fifo_full, 0);
    tick();
    tick();
    rst4 = 1'b0;
    clear_stim();
    run4(100);
    bad = 0;
    for (int e = 0; e < 100; e++) begin
      if (tx_o[e] !== 1'b1 || busy_o[e] !== 1'b0) bad++;
    end
    check("t5_quiet_after", bad, 0);

    // 4: overflow counter saturation with a stalled long frame
    rst_big = 1'b0;
    tick();
    prev = 0;
    wraps = 0;
    for (int e = 0; e < 300; e++) begin
      if_big.sys_odata = {1'b1, 8'(e)};
      tick();
      if (int'(if_big.overflow_cnt) < prev) wraps++;
      prev = int'(if_big.overflow_cnt);
      if (e == 16)  check("t4_full_e16", if_big.fifo_full, 1);
      if (e == 17)  check("t4_ovf_e17", if_big.overflow_cnt, 1);
      if (e == 100) check("t4_ovf_e100", if_big.overflow_cnt, 84);
      if (e == 271) check("t4_ovf_e271", if_big.overflow_cnt, 255);
    end
    if_big.sys_odata = '0;
    check("t4_ovf_end", if_big.overflow_cnt, 255);
    check("t4_no_wrap", wraps, 0);
    check("t4_tx_start", if_big.serial_tx, 0);

    // 6: DIVISOR=2 random traffic against the receiver model
    rst2 = 1'b0;
    tick();
    for (int c = 0; c < 620; c++) begin
      if (c < 200)      v = ($urandom_range(15) == 0);
      else if (c < 220) v = 1'b1;
      else if (c < 420) v = ($urandom_range(3) == 0);
      else              v = 1'b0;
      if (v) begin
        if2.sys_odata = {1'b1, 8'($urandom_range(255))};
        sent_q.push_back(if2.sys_odata[7:0]);
      end else begin
        if2.sys_odata = {1'b0, 8'($urandom_range(255))};
      end
      tick();
    end
    if2.sys_odata = '0;
    waited = 0;
    while (if2.busy && waited < 3000) begin
      tick();
      waited++;
    end
    check("t6_drain", if2.busy, 0);
    repeat (30) tick();
    j = 0;
    foreach (sent_q[i]) begin
      if (j < rx_q.size() && rx_q[j] == sent_q[i]) j++;
    end
    check("t6_in_order", j, rx_q.size());
    check("t6_drops", if2.overflow_cnt, sent_q.size() - rx_q.size());
    check("t6_some_drops", (if2.overflow_cnt != 0), 1);
    check("t6_framing", rx_frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
